// File: rtl/usb_in_ep_arbiter.sv
// -----------------------------------------------------------------------------
// usb_in_ep_arbiter
//
// Shares one USB IN endpoint between two byte-stream clients (for example the
// UART bridge and a tone/status reporter). Ownership is granted per packet,
// round-robin. The block drives the endpoint req/put/done handshake and closes
// a packet when it reaches MAX_PKT bytes, when the owning client has been idle
// for FLUSH_TIMEOUT cycles, or when the endpoint buffer reports full.
//
// Parameters
//   MAX_PKT        maximum bytes per IN packet (1..64)
//   FLUSH_TIMEOUT  idle cycles of the owning client before a partial packet
//                  is closed (1..65535)
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   c0_valid/data      client 0 byte offer
//   c0_ready           client 0 byte accepted this cycle (with c0_valid)
//   c1_valid/data      client 1 byte offer
//   c1_ready           client 1 byte accepted this cycle (with c1_valid)
//   in_ep_req          IN endpoint request (held for the whole packet)
//   in_ep_grant        IN endpoint grant
//   in_ep_data_free    endpoint buffer can take a byte
//   in_ep_data_put     byte write strobe
//   in_ep_data         byte to endpoint
//   in_ep_data_done    one-cycle packet-complete strobe
//   in_ep_stall        tied low
//   in_ep_acked        reserved, not used
//   owner              index of the current or last granted client
//   busy               high whenever the arbiter is not in IDLE
//
// Handshake: a client byte transfers on a cycle where cN_valid and cN_ready
// are both high. cN_ready does not depend on cN_valid, so a client may hold
// valid and data stable until it sees ready. The same cycle raises
// in_ep_data_put with the byte on in_ep_data (no pipeline stage).
// -----------------------------------------------------------------------------
module usb_in_ep_arbiter #(
    parameter int MAX_PKT       = 32,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       c0_valid,
    input  logic [7:0] c0_data,
    output logic       c0_ready,

    input  logic       c1_valid,
    input  logic [7:0] c1_data,
    output logic       c1_ready,

    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked,

    output logic       owner,
    output logic       busy
);

    localparam int CW = $clog2(MAX_PKT + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PKT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_PKT - 1);
    localparam logic [15:0]   IDLE_LAST = 16'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_XFER = 3'd2,
        ST_DONE = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] count;       // bytes already put in the current packet
    logic [15:0]   idle_cnt;    // consecutive XFER cycles without a put
    logic          last_owner;  // owner of the most recently closed packet

    logic          sel;         // client picked in IDLE
    logic          sel_vld;     // some client is offering a byte in IDLE
    logic          own_valid;
    logic          ready_owner;
    logic          put;
    logic          timeout;
    logic          close_pkt;   // XFER ends with a done strobe
    logic          abandon;     // XFER ends with nothing sent: drop req quietly

    // The reserved acknowledge input has no function in this block.
    logic          unused_acked;
    assign unused_acked = in_ep_acked;

    assign in_ep_stall = 1'b0;

    // -------------------------------------------------------------------------
    // Client selection in IDLE. On contention the client that did not own
    // the previous packet wins, which gives packet-granular round-robin.
    // -------------------------------------------------------------------------
    always_comb begin
        sel     = 1'b0;
        sel_vld = c0_valid | c1_valid;
        if (c0_valid && c1_valid) begin
            sel = ~last_owner;
        end else if (c1_valid) begin
            sel = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // A client dropping valid here does not cancel the request;
                // the idle timeout in XFER cleans up instead.
                if (in_ep_grant && in_ep_data_free) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (close_pkt) begin
                    state_nxt = ST_DONE;
                end else if (abandon) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath decode. Everything client-facing is gated by reset so
    // no byte can be accepted on a reset cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        own_valid   = owner ? c1_valid : c0_valid;
        ready_owner = !reset && (state == ST_XFER) && in_ep_grant &&
                      in_ep_data_free && (count < CNT_MAX);
        put         = own_valid && ready_owner;

        c0_ready        = ready_owner && !owner;
        c1_ready        = ready_owner &&  owner;
        in_ep_data_put  = put;
        in_ep_data      = reset ? 8'h00 : (owner ? c1_data : c0_data);
        busy            = (state != ST_IDLE);

        // Close conditions, highest priority first: full packet, endpoint
        // buffer full with data pending, idle timeout with data pending.
        // A timeout with nothing put abandons the request so no zero-length
        // packet is ever produced.
        timeout   = !put && (idle_cnt == IDLE_LAST);
        close_pkt = (put && (count == CNT_LAST)) ||
                    ((count != '0) && !in_ep_data_free) ||
                    (timeout && (count != '0));
        abandon   = timeout && (count == '0);
    end

    // -------------------------------------------------------------------------
    // Registered endpoint signals and packet counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ep_req       <= 1'b0;
            in_ep_data_done <= 1'b0;
            count           <= '0;
            idle_cnt        <= '0;
            last_owner      <= 1'b1;   // client 0 wins the first contention
            owner           <= 1'b0;
        end else begin
            in_ep_data_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        owner     <= sel;
                        in_ep_req <= 1'b1;
                        count     <= '0;
                        idle_cnt  <= '0;
                    end
                end
                ST_XFER: begin
                    if (put) begin
                        count    <= count + 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cnt != 16'hFFFF) begin
                        // Keeps counting while grant is lost, so the
                        // timeout path still closes the packet.
                        idle_cnt <= idle_cnt + 16'd1;
                    end

                    // The done strobe is registered so it lines up exactly
                    // with the DONE state, and req falls in the same cycle.
                    if (close_pkt) begin
                        in_ep_data_done <= 1'b1;
                        in_ep_req       <= 1'b0;
                        last_owner      <= owner;
                    end else if (abandon) begin
                        in_ep_req  <= 1'b0;
                        last_owner <= owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for usb_in_ep_arbiter (MAX_PKT=4, FLUSH_TIMEOUT=8).
// Inputs change on the falling edge, outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_usb_in_ep_arbiter;

    localparam int MAX_PKT = 4;
    localparam int FT      = 8;

    // ---------------------------------------------------------------- DUT I/O
    logic       clk;
    logic       reset;
    logic       c0_valid, c1_valid;
    logic [7:0] c0_data, c1_data;
    logic       c0_ready, c1_ready;
    logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done, in_ep_stall, in_ep_acked;
    logic       owner, busy;

    usb_in_ep_arbiter #(
        .MAX_PKT       (MAX_PKT),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .c0_valid        (c0_valid),
        .c0_data         (c0_data),
        .c0_ready        (c0_ready),
        .c1_valid        (c1_valid),
        .c1_data         (c1_data),
        .c1_ready        (c1_ready),
        .in_ep_req       (in_ep_req),
        .in_ep_grant     (in_ep_grant),
        .in_ep_data_free (in_ep_data_free),
        .in_ep_data_put  (in_ep_data_put),
        .in_ep_data      (in_ep_data),
        .in_ep_data_done (in_ep_data_done),
        .in_ep_stall     (in_ep_stall),
        .in_ep_acked     (in_ep_acked),
        .owner           (owner),
        .busy            (busy)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ bookkeeping
    int         n_chk;
    int         n_fail;
    int         cyc;

    logic [7:0] exp_q0[$];      // scoreboard: bytes client 0 must deliver
    logic [7:0] exp_q1[$];
    logic [7:0] drv_q0[$];      // client sources: bytes still to offer
    logic [7:0] drv_q1[$];

    int         put_cyc[$];
    int         done_cyc[$];
    int         req_rise[$];
    logic       pkt_own[$];

    logic       en0, en1;
    logic       rst_drv, grant_drv, free_drv;
    logic       prev_done, prev_req;

    typedef struct {
        logic       c0_valid;
        logic [7:0] c0_data;
        logic       c1_valid;
        logic [7:0] c1_data;
        logic       grant;
        logic       free;
        logic       exp_c0_ready;
        logic       exp_c1_ready;
        logic       exp_put;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic client, input logic [7:0] b);
        if (client) begin
            drv_q1.push_back(b);
            exp_q1.push_back(b);
        end else begin
            drv_q0.push_back(b);
            exp_q0.push_back(b);
        end
    endtask

    task automatic clr();
        put_cyc.delete();
        done_cyc.delete();
        req_rise.delete();
        pkt_own.delete();
        prev_req = in_ep_req;
    endtask

    task automatic flush_clients();
        drv_q0.delete();
        drv_q1.delete();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // One clock cycle: drive inputs, then monitor and score the outputs.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        reset           = rst_drv;
        in_ep_grant     = grant_drv;
        in_ep_data_free = free_drv;
        c0_valid = en0 && (drv_q0.size() != 0);
        c0_data  = c0_valid ? drv_q0[0] : 8'h00;
        c1_valid = en1 && (drv_q1.size() != 0);
        c1_data  = c1_valid ? drv_q1[0] : 8'h00;
        #2;

        if (in_ep_data_put) begin
            put_cyc.push_back(cyc);
            if (!owner) begin
                if (exp_q0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_extra_put_c0: got put of 0x%0h, required no put", in_ep_data);
                end else begin
                    e = exp_q0.pop_front();
                    chk("sb_data_c0", 32'(in_ep_data), 32'(e));
                end
            end else begin
                if (exp_q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_extra_put_c1: got put of 0x%0h, required no put", in_ep_data);
                end else begin
                    e = exp_q1.pop_front();
                    chk("sb_data_c1", 32'(in_ep_data), 32'(e));
                end
            end
        end

        if (c0_ready || c1_ready) begin
            chk("ready_owner_only", 32'({c1_ready, c0_ready}), owner ? 32'd2 : 32'd1);
        end

        if (in_ep_data_done) begin
            done_cyc.push_back(cyc);
            pkt_own.push_back(owner);
            chk("req_drops_with_done", 32'(in_ep_req), 32'd0);
            chk("done_one_cycle", 32'(prev_done), 32'd0);
        end
        if (in_ep_req && !prev_req) req_rise.push_back(cyc);
        prev_done = in_ep_data_done;
        prev_req  = in_ep_req;

        if (c0_valid && c0_ready) drv_q0.delete(0);
        if (c1_valid && c1_ready) drv_q1.delete(0);
    endtask

    // Run until both client sources are empty and the arbiter is back in IDLE.
    task automatic drain(input string name, input int budget);
        logic fin;
        fin = 1'b0;
        for (int i = 0; i < budget && !fin; i++) begin
            step();
            fin = (drv_q0.size() == 0) && (drv_q1.size() == 0) && !busy;
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    // ------------------------------------------------------------- main test
    initial begin
        logic dropped;
        logic fin;
        int   a_cyc;
        int   ret_cyc;

        n_chk = 0; n_fail = 0; cyc = 0;
        en0 = 1'b0; en1 = 1'b0;
        prev_done = 1'b0; prev_req = 1'b0;
        rst_drv = 1'b1; grant_drv = 1'b1; free_drv = 1'b1;

        // ---- reset state, with both clients pushing during reset
        reset = 1'b1;
        c0_valid = 1'b1; c0_data = 8'hAA;
        c1_valid = 1'b1; c1_data = 8'h55;
        in_ep_grant = 1'b1; in_ep_data_free = 1'b1; in_ep_acked = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_req",     32'(in_ep_req),       32'd0);
        chk("rst_done",    32'(in_ep_data_done), 32'd0);
        chk("rst_put",     32'(in_ep_data_put),  32'd0);
        chk("rst_c0_rdy",  32'(c0_ready),        32'd0);
        chk("rst_c1_rdy",  32'(c1_ready),        32'd0);
        chk("rst_data",    32'(in_ep_data),      32'd0);
        chk("rst_busy",    32'(busy),            32'd0);
        chk("rst_owner",   32'(owner),           32'd0);
        chk("rst_stall",   32'(in_ep_stall),     32'd0);

        // ---- table-driven XFER datapath, owner 0, packet empty at start
        vecs[0] = '{1'b0, 8'h5A, 1'b1, 8'hA5, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[1] = '{1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 8'h11};
        vecs[2] = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 8'h33};
        vecs[3] = '{1'b1, 8'h66, 1'b0, 8'h77, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'h66};
        vecs[4] = '{1'b0, 8'h88, 1'b1, 8'h99, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'h88};
        vecs[5] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 8'hC3};

        @(negedge clk);                 // IDLE: client 0 alone -> REQ
        reset = 1'b0; rst_drv = 1'b0;
        c0_valid = 1'b1; c0_data = 8'h10; c1_valid = 1'b0; in_ep_grant = 1'b0;
        @(negedge clk);                 // REQ: grant and free -> XFER
        c0_valid = 1'b0; in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c0_valid = vecs[i].c0_valid; c0_data = vecs[i].c0_data;
            c1_valid = vecs[i].c1_valid; c1_data = vecs[i].c1_data;
            in_ep_grant = vecs[i].grant; in_ep_data_free = vecs[i].free;
            #2;
            chk($sformatf("vec%0d_c0_ready", i), 32'(c0_ready),       32'(vecs[i].exp_c0_ready));
            chk($sformatf("vec%0d_c1_ready", i), 32'(c1_ready),       32'(vecs[i].exp_c1_ready));
            chk($sformatf("vec%0d_put", i),      32'(in_ep_data_put), 32'(vecs[i].exp_put));
            chk($sformatf("vec%0d_data", i),     32'(in_ep_data),     32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_busy", i),     32'(busy),           32'd1);
        end
        // One byte is in the packet; it must be closed by the idle timeout.
        clr();
        grant_drv = 1'b1; free_drv = 1'b1;
        drain("table_tail", 40);
        chk("table_tail_dones", 32'(done_cyc.size()), 32'd1);
        chk("table_tail_puts",  32'(put_cyc.size()),  32'd0);
        if (pkt_own.size() == 1) chk("table_tail_owner", 32'(pkt_own[0]), 32'd0);

        // ---- single client, 3 bytes, closed by timeout
        clr();
        en0 = 1'b1; en1 = 1'b0;
        send(1'b0, 8'h41); send(1'b0, 8'h42); send(1'b0, 8'h43);
        drain("single", 60);
        chk("single_puts",  32'(put_cyc.size()),  32'd3);
        chk("single_dones", 32'(done_cyc.size()), 32'd1);
        // FT idle cycles separate the last put from the done cycle.
        if (put_cyc.size() == 3 && done_cyc.size() == 1)
            chk("single_done_delay", 32'(done_cyc[0] - put_cyc[2]), 32'(FT + 1));

        // ---- max length: 6 bytes from client 1 -> 4-byte packet + 2-byte packet
        clr();
        en0 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 6; i++) send(1'b1, 8'hB0 + 8'(i));
        drain("maxlen", 100);
        chk("maxlen_puts",  32'(put_cyc.size()),  32'd6);
        chk("maxlen_dones", 32'(done_cyc.size()), 32'd2);
        if (put_cyc.size() == 6 && done_cyc.size() == 2) begin
            chk("maxlen_done_after_4th", 32'(done_cyc[0]), 32'(put_cyc[3] + 1));
            chk("maxlen_5th_after_done", 32'(put_cyc[4] > done_cyc[0]), 32'd1);
            chk("maxlen_owner0", 32'(pkt_own[0]), 32'd1);
            chk("maxlen_owner1", 32'(pkt_own[1]), 32'd1);
        end
        // DONE, GAP and IDLE all have req low; the new req appears after them.
        chk("maxlen_req_rises", 32'(req_rise.size()), 32'd2);
        if (req_rise.size() == 2 && done_cyc.size() >= 1)
            chk("maxlen_req_spacing", 32'(req_rise[1] - done_cyc[0]), 32'd3);

        // ---- round-robin contention from reset
        rst_drv = 1'b1;
        step(); step();
        rst_drv = 1'b0;
        clr();
        en0 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 8'h00 + 8'(i));
            send(1'b1, 8'h80 + 8'(i));
        end
        drain("rr", 200);
        chk("rr_puts",  32'(put_cyc.size()),  32'd12);
        chk("rr_dones", 32'(done_cyc.size()), 32'd4);
        if (pkt_own.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr_owner%0d", i), 32'(pkt_own[i]), 32'(i % 2));
        end

        // ---- endpoint buffer full after 2 puts
        clr();
        en0 = 1'b1; en1 = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 8'hF0 + 8'(i));
        dropped = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            free_drv = 1'b1;
            if (put_cyc.size() == 2 && !dropped) begin
                free_drv = 1'b0;
                dropped  = 1'b1;
            end
            step();
            fin = (drv_q0.size() == 0) && !busy;
        end
        free_drv = 1'b1;
        chk("full_finished", 32'(fin), 32'd1);
        chk("full_puts",  32'(put_cyc.size()),  32'd4);
        chk("full_dones", 32'(done_cyc.size()), 32'd2);
        if (put_cyc.size() == 4 && done_cyc.size() == 2) begin
            chk("full_done_next_cycle", 32'(done_cyc[0]), 32'(put_cyc[1] + 2));
            chk("full_held_byte_later", 32'(put_cyc[2] > done_cyc[0]), 32'd1);
        end

        // ---- abandoned request: 1-cycle valid pulse, grant 3 cycles later
        clr();
        flush_clients();
        send(1'b0, 8'h55);
        en0 = 1'b1; en1 = 1'b0;
        grant_drv = 1'b0;
        step();
        a_cyc = cyc;
        en0 = 1'b0;
        step(); step();
        grant_drv = 1'b1;
        ret_cyc = -1;
        for (int i = 0; i < 40 && ret_cyc < 0; i++) begin
            step();
            if (!busy) ret_cyc = cyc;
        end
        chk("abandon_return_cycle", 32'(ret_cyc), 32'(a_cyc + 4 + FT));
        chk("abandon_req_low", 32'(in_ep_req), 32'd0);
        chk("abandon_no_put",  32'(put_cyc.size()),  32'd0);
        chk("abandon_no_done", 32'(done_cyc.size()), 32'd0);
        flush_clients();

        // ---- reset in the middle of a packet
        clr();
        en0 = 1'b1; en1 = 1'b1;
        send(1'b0, 8'hC0); send(1'b0, 8'hC1); send(1'b0, 8'hC2);
        send(1'b1, 8'hE0);
        fin = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            step();
            fin = (put_cyc.size() == 1);
        end
        chk("midrst_first_put", 32'(fin), 32'd1);
        rst_drv = 1'b1;
        step();
        step();
        chk("midrst_req",  32'(in_ep_req),       32'd0);
        chk("midrst_put",  32'(in_ep_data_put),  32'd0);
        chk("midrst_done", 32'(in_ep_data_done), 32'd0);
        chk("midrst_busy", 32'(busy),            32'd0);
        rst_drv = 1'b0;
        flush_clients();
        clr();
        send(1'b1, 8'hE1);
        send(1'b0, 8'hD0);
        step();
        step();
        chk("midrst_first_owner", 32'(owner),     32'd0);
        chk("midrst_req_up",      32'(in_ep_req), 32'd1);
        drain("midrst", 100);
        chk("midrst_dones", 32'(pkt_own.size()), 32'd2);
        if (pkt_own.size() == 2) begin
            chk("midrst_owner0", 32'(pkt_own[0]), 32'd0);
            chk("midrst_owner1", 32'(pkt_own[1]), 32'd1);
        end

        // ---- every queued byte reached the endpoint
        chk("sb_c0_empty", 32'(exp_q0.size()), 32'd0);
        chk("sb_c1_empty", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
